srio_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter merging three SRIO HELLO-format AXI-Stream sources (e.g. srio_dma, srio_fifo, maintenance/response path) onto the single SRIO core transmit stream.
- Grant is held for a whole packet, from the first beat through the TLAST beat.
- Output goes through one register stage. M_AXIS_TID reports the granted source.
- Also provides an arbitration enable, a fixed-priority override for one source, and an oversize-packet monitor.

---
 rtl/srio_tx_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_srio_tx_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srio_tx_arbiter.sv
// Packet-level round-robin arbiter: three SRIO HELLO AXI-Stream sources onto one
// registered transmit stream, with grant hold per packet, priority override and oversize monitor.
`timescale 1ns/1ps
module srio_tx_arbiter #(
    parameter int DATA_W    = 64,
    parameter int USER_W    = 32,
    parameter int MAX_BEATS = 33
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESETN,
    input  logic              S0_AXIS_TVALID,
    output logic              S0_AXIS_TREADY,
    input  logic [DATA_W-1:0] S0_AXIS_TDATA,
    input  logic              S0_AXIS_TLAST,
    input  logic [USER_W-1:0] S0_AXIS_TUSER,
    input  logic              S1_AXIS_TVALID,
    output logic              S1_AXIS_TREADY,
    input  logic [DATA_W-1:0] S1_AXIS_TDATA,
    input  logic              S1_AXIS_TLAST,
    input  logic [USER_W-1:0] S1_AXIS_TUSER,
    input  logic              S2_AXIS_TVALID,
    output logic              S2_AXIS_TREADY,
    input  logic [DATA_W-1:0] S2_AXIS_TDATA,
    input  logic              S2_AXIS_TLAST,
    input  logic [USER_W-1:0] S2_AXIS_TUSER,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic [USER_W-1:0] M_AXIS_TUSER,
    output logic [1:0]        M_AXIS_TID,
    input  logic              arb_enable,
    input  logic              prio_en,
    input  logic [1:0]        prio_sel,
    output logic              grant_active,
    output logic              oversize_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);
    localparam logic [7:0] CNT_SAT = 8'hFF;

    logic [2:0]        s_valid;
    logic [2:0]        s_last;
    logic [2:0]        s_ready;
    logic [DATA_W-1:0] s_data [3];
    logic [USER_W-1:0] s_user [3];

    assign s_valid   = {S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};
    assign s_last    = {S2_AXIS_TLAST, S1_AXIS_TLAST, S0_AXIS_TLAST};
    assign s_data[0] = S0_AXIS_TDATA;
    assign s_data[1] = S1_AXIS_TDATA;
    assign s_data[2] = S2_AXIS_TDATA;
    assign s_user[0] = S0_AXIS_TUSER;
    assign s_user[1] = S1_AXIS_TUSER;
    assign s_user[2] = S2_AXIS_TUSER;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              ovs_seen_q, ovs_seen_d;
    logic              oversize_q, oversize_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [USER_W-1:0] m_user_q, m_user_d;
    logic [1:0]        m_tid_q, m_tid_d;

    logic              load_ok;
    logic              accept;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [USER_W-1:0] sel_user;
    logic              prio_hit;
    logic              any_valid;
    logic [1:0]        rr_winner;
    logic [1:0]        rr_cand;
    logic              rr_found;
    logic [1:0]        winner;

    // The register can take a beat when empty or when it drains this cycle.
    assign load_ok   = !m_valid_q || M_AXIS_TREADY;
    assign sel_valid = s_valid[grant_q];
    assign sel_last  = s_last[grant_q];
    assign sel_data  = s_data[grant_q];
    assign sel_user  = s_user[grant_q];
    assign accept    = (state_q == ST_GNT) && load_ok && sel_valid;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ready
            assign s_ready[gi] = (state_q == ST_GNT) && load_ok && (grant_q == 2'(gi));
        end
    endgenerate

    assign S0_AXIS_TREADY = s_ready[0];
    assign S1_AXIS_TREADY = s_ready[1];
    assign S2_AXIS_TREADY = s_ready[2];

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search starts just after the source served last.
    always_comb begin
        rr_winner = rr_next(last_grant_q);
        rr_cand   = last_grant_q;
        rr_found  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rr_cand = rr_next(rr_cand);
            if (!rr_found && s_valid[rr_cand]) begin
                rr_winner = rr_cand;
                rr_found  = 1'b1;
            end
        end
    end

    assign prio_hit  = prio_en && (prio_sel != 2'd3) && s_valid[prio_sel];
    assign winner    = prio_hit ? prio_sel : rr_winner;
    assign any_valid = |s_valid;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        ovs_seen_d   = ovs_seen_q;
        oversize_d   = 1'b0;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        m_user_d     = m_user_q;
        m_tid_d      = m_tid_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_enable && any_valid) begin
                    state_d = ST_GNT;
                    grant_d = winner;
                end
            end
            ST_GNT: begin
                if (accept) begin
                    // The beat taking the count past MAX_BEATS flags the packet once.
                    if ((beat_cnt_q == MAX_CNT) && !ovs_seen_q) begin
                        oversize_d = 1'b1;
                        ovs_seen_d = 1'b1;
                    end
                    if (beat_cnt_q != CNT_SAT) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                    if (sel_last) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                        beat_cnt_d   = 8'd0;
                        ovs_seen_d   = 1'b0;
                    end
                end
            end
        endcase

        if (accept) begin
            m_valid_d = 1'b1;
            m_last_d  = sel_last;
            m_data_d  = sel_data;
            m_user_d  = sel_user;
            m_tid_d   = grant_q;
        end else if (M_AXIS_TREADY) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
            beat_cnt_q   <= 8'd0;
            ovs_seen_q   <= 1'b0;
            oversize_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            m_user_q     <= '0;
            m_tid_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            ovs_seen_q   <= ovs_seen_d;
            oversize_q   <= oversize_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            m_user_q     <= m_user_d;
            m_tid_q      <= m_tid_d;
        end
    end

    assign M_AXIS_TVALID = m_valid_q;
    assign M_AXIS_TDATA  = m_data_q;
    assign M_AXIS_TLAST  = m_last_q;
    assign M_AXIS_TUSER  = m_user_q;
    assign M_AXIS_TID    = m_tid_q;
    assign grant_active  = (state_q == ST_GNT);
    assign oversize_err  = oversize_q;

endmodule

// File: tb/tb_srio_tx_arbiter.sv
// Randomized bench for srio_tx_arbiter: per-source packet queues, a cycle-level
// behavioural model compared every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_srio_tx_arbiter;
    localparam int DW   = 64;
    localparam int UW   = 32;
    localparam int MAXB = 33;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          s_tvalid [3];
    logic          s_tready [3];
    logic [DW-1:0] s_tdata  [3];
    logic          s_tlast  [3];
    logic [UW-1:0] s_tuser  [3];
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic [1:0]    m_tid;
    logic          arb_enable, prio_en, grant_active, oversize_err;
    logic [1:0]    prio_sel;

    srio_tx_arbiter #(.DATA_W(DW), .USER_W(UW), .MAX_BEATS(MAXB)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
        .S0_AXIS_TVALID(s_tvalid[0]), .S0_AXIS_TREADY(s_tready[0]), .S0_AXIS_TDATA(s_tdata[0]),
        .S0_AXIS_TLAST(s_tlast[0]), .S0_AXIS_TUSER(s_tuser[0]),
        .S1_AXIS_TVALID(s_tvalid[1]), .S1_AXIS_TREADY(s_tready[1]), .S1_AXIS_TDATA(s_tdata[1]),
        .S1_AXIS_TLAST(s_tlast[1]), .S1_AXIS_TUSER(s_tuser[1]),
        .S2_AXIS_TVALID(s_tvalid[2]), .S2_AXIS_TREADY(s_tready[2]), .S2_AXIS_TDATA(s_tdata[2]),
        .S2_AXIS_TLAST(s_tlast[2]), .S2_AXIS_TUSER(s_tuser[2]),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata),
        .M_AXIS_TLAST(m_tlast), .M_AXIS_TUSER(m_tuser), .M_AXIS_TID(m_tid),
        .arb_enable(arb_enable), .prio_en(prio_en), .prio_sel(prio_sel),
        .grant_active(grant_active), .oversize_err(oversize_err)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        bit            known;
        bit            gnt;
        int            g;
        int            lg;
        int            cnt;
        bit            full;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        bit            lastb;
        int            tid;
        bit            ovs;
    } model_t;

    beat_t  srcq [3][$];
    model_t md, nx;
    bit     pop_pend [3];

    bit         rst_ctl      = 1'b0;
    bit         arb_ctl      = 1'b1;
    bit         prio_en_ctl  = 1'b0;
    logic [1:0] prio_sel_ctl = 2'd0;
    int         vprob [3]    = '{100, 100, 100};
    int         rprob        = 100;

    int checks = 0;
    int errors = 0;
    int out_beats = 0;
    int out_lasts = 0;
    int ovs_pulses = 0;
    int pkt_log [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < pkt_log.size()) ? pkt_log[i] : -1;
    endfunction

    task automatic push_pkt(input int s, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.user = $urandom;
            b.last = (i == len - 1);
            srcq[s].push_back(b);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size() != 0 || m_tvalid || grant_active)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_in_budget"}, 64'(n < budget), 64'd1);
        #2;
    endtask

    // Driver, behavioural model and per-cycle comparison.
    initial begin
        bit ready_ok;
        int w;
        md.known = 1'b0;
        rst_n = 1'b0; m_tready = 1'b0; arb_enable = 1'b1; prio_en = 1'b0; prio_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid[i] = 1'b0; s_tdata[i] = '0; s_tlast[i] = 1'b0; s_tuser[i] = '0;
            pop_pend[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (pop_pend[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                pop_pend[i] = 1'b0;
            end
            md = nx;
            rst_n      = rst_ctl;
            arb_enable = arb_ctl;
            prio_en    = prio_en_ctl;
            prio_sel   = prio_sel_ctl;
            m_tready   = ($urandom_range(99) < rprob);
            for (int i = 0; i < 3; i++) begin
                if (srcq[i].size() > 0) begin
                    s_tvalid[i] = ($urandom_range(99) < vprob[i]);
                    s_tdata[i]  = srcq[i][0].data;
                    s_tuser[i]  = srcq[i][0].user;
                    s_tlast[i]  = srcq[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tdata[i]  = {$urandom, $urandom};
                    s_tuser[i]  = $urandom;
                    s_tlast[i]  = $urandom_range(1);
                end
            end

            @(negedge clk);
            ready_ok = !md.full || m_tready;
            if (md.known) begin
                chk("m_tvalid", 64'(m_tvalid), 64'(md.full));
                chk("m_tdata", m_tdata, md.data);
                chk("m_tlast", 64'(m_tlast), 64'(md.lastb));
                chk("m_tuser", 64'(m_tuser), 64'(md.user));
                chk("m_tid", 64'(m_tid), 64'(md.tid));
                chk("grant_active", 64'(grant_active), 64'(md.gnt));
                chk("oversize_err", 64'(oversize_err), 64'(md.ovs));
                for (int i = 0; i < 3; i++)
                    chk($sformatf("s%0d_tready", i), 64'(s_tready[i]),
                        64'(md.gnt && md.g == i && ready_ok));
            end
            for (int i = 0; i < 3; i++) pop_pend[i] = s_tvalid[i] && s_tready[i];
            if (m_tvalid && m_tready) begin
                out_beats++;
                if (m_tlast) begin
                    out_lasts++;
                    pkt_log.push_back(int'(m_tid));
                end
            end
            if (oversize_err) ovs_pulses++;

            nx = md;
            if (!rst_n) begin
                nx.known = 1'b1; nx.gnt = 1'b0; nx.g = 0; nx.lg = 2; nx.cnt = 0;
                nx.full = 1'b0; nx.data = '0; nx.user = '0; nx.lastb = 1'b0; nx.tid = 0; nx.ovs = 1'b0;
            end else if (md.known) begin
                nx.ovs = 1'b0;
                if (md.gnt && ready_ok && s_tvalid[md.g]) begin
                    nx.full  = 1'b1;
                    nx.data  = s_tdata[md.g];
                    nx.user  = s_tuser[md.g];
                    nx.lastb = s_tlast[md.g];
                    nx.tid   = md.g;
                    nx.cnt   = md.cnt + 1;
                    if (nx.cnt == MAXB + 1) nx.ovs = 1'b1;
                    if (s_tlast[md.g]) begin
                        nx.gnt = 1'b0; nx.lg = md.g; nx.cnt = 0;
                    end
                end else if (m_tready) begin
                    nx.full = 1'b0;
                end
                if (!md.gnt && arb_enable) begin
                    w = -1;
                    if (prio_en && prio_sel < 3 && s_tvalid[prio_sel]) w = int'(prio_sel);
                    else
                        for (int k = 1; k <= 3; k++)
                            if (w < 0 && s_tvalid[(md.lg + k) % 3]) w = (md.lg + k) % 3;
                    if (w >= 0) begin
                        nx.gnt = 1'b1; nx.g = w;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a randomized soak.
    initial begin
        int exp_v [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
        int exp_t [6] = '{0, 0, 1, 1, 2, 2};
        int tq [$];
        int vlog [9];
        bit ga0, tr0;
        int n;

        // Reset with all sources valid, then release.
        for (int s = 0; s < 3; s++) push_pkt(s, 2);
        wait_neg(3);
        rst_ctl = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            vlog[k] = int'(m_tvalid);
            if (m_tvalid) tq.push_back(int'(m_tid));
            if (k == 0) begin
                ga0 = grant_active;
                tr0 = s_tready[0];
            end
        end
        chk("p1_grant_after_release", 64'(ga0), 64'd1);
        chk("p1_s0_tready_after_release", 64'(tr0), 64'd1);
        for (int k = 0; k < 9; k++) chk($sformatf("p1_valid_cyc%0d", k), 64'(vlog[k]), 64'(exp_v[k]));
        chk("p1_tid_count", 64'(tq.size()), 64'd6);
        for (int k = 0; k < 6 && k < tq.size(); k++)
            chk($sformatf("p1_tid_%0d", k), 64'(tq[k]), 64'(exp_t[k]));
        #2;
        drain("p1", 100);

        // Fairness with all sources saturated.
        pkt_log.delete();
        for (int r = 0; r < 4; r++) for (int s = 0; s < 3; s++) push_pkt(s, 4);
        drain("p2", 400);
        chk("p2_pkts", 64'(pkt_log.size()), 64'd12);
        for (int i = 0; i < 12; i++) chk($sformatf("p2_order_%0d", i), 64'(log_at(i)), 64'(i % 3));

        // Backpressure on a 5-beat packet from S1.
        out_beats = 0; out_lasts = 0; rprob = 40;
        push_pkt(1, 5);
        drain("p3", 300);
        chk("p3_beats", 64'(out_beats), 64'd5);
        chk("p3_lasts", 64'(out_lasts), 64'd1);
        rprob = 100;

        // Fixed-priority override for S2 against S0.
        pkt_log.delete(); prio_en_ctl = 1'b1; prio_sel_ctl = 2'd2;
        for (int r = 0; r < 3; r++) begin
            push_pkt(0, 3);
            push_pkt(2, 3);
        end
        drain("p4a", 300);
        for (int i = 0; i < 6; i++) chk($sformatf("p4a_order_%0d", i), 64'(log_at(i)), 64'(i < 3 ? 2 : 0));
        prio_en_ctl = 1'b0;

        // arb_enable dropped mid-packet.
        pkt_log.delete();
        push_pkt(0, 10);
        wait_neg(4);
        arb_ctl = 1'b0;
        push_pkt(1, 4);
        wait_neg(30);
        chk("p4b_pkts_while_disabled", 64'(pkt_log.size()), 64'd1);
        chk("p4b_first_src", 64'(log_at(0)), 64'd0);
        chk("p4b_grant_idle", 64'(grant_active), 64'd0);
        chk("p4b_s1_waiting", 64'(srcq[1].size()), 64'd4);
        arb_ctl = 1'b1;
        drain("p4b", 200);
        chk("p4b_second_src", 64'(log_at(1)), 64'd1);

        // Oversize monitor: 34 beats pulses once, 33 beats does not.
        ovs_pulses = 0; out_beats = 0;
        push_pkt(0, MAXB + 1);
        drain("p5a", 500);
        chk("p5_pulse_34", 64'(ovs_pulses), 64'd1);
        chk("p5_beats_34", 64'(out_beats), 64'(MAXB + 1));
        push_pkt(0, MAXB);
        drain("p5b", 500);
        chk("p5_pulse_33", 64'(ovs_pulses), 64'd1);
        chk("p5_beats_total", 64'(out_beats), 64'(2 * MAXB + 1));

        // Reset mid-packet with the output register full.
        rprob = 30; out_beats = 0;
        push_pkt(1, 8);
        n = 0;
        while ((out_beats < 2 || !m_tvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("p6_reached_mid_packet", 64'(n < 300), 64'd1);
        #2;
        rst_ctl = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("p6_tvalid_after_reset", 64'(m_tvalid), 64'd0);
        chk("p6_grant_after_reset", 64'(grant_active), 64'd0);
        for (int i = 0; i < 3; i++) chk($sformatf("p6_s%0d_tready_reset", i), 64'(s_tready[i]), 64'd0);
        #2;
        for (int i = 0; i < 3; i++) srcq[i].delete();
        rst_ctl = 1'b1; rprob = 100;
        pkt_log.delete();
        push_pkt(2, 1); push_pkt(1, 1); push_pkt(0, 1);
        drain("p6", 100);
        for (int i = 0; i < 3; i++) chk($sformatf("p6_order_%0d", i), 64'(log_at(i)), 64'(i));

        // Randomized soak.
        for (int blk = 0; blk < 60; blk++) begin
            for (int s = 0; s < 3; s++) begin
                vprob[s] = $urandom_range(100);
                if (srcq[s].size() < 20)
                    push_pkt(s, ($urandom_range(9) == 0) ? $urandom_range(36, 30) : $urandom_range(6, 1));
            end
            rprob        = $urandom_range(100, 20);
            arb_ctl      = ($urandom_range(3) != 0);
            prio_en_ctl  = ($urandom_range(2) == 0);
            prio_sel_ctl = 2'($urandom_range(3));
            wait_neg(50);
        end
        vprob = '{100, 100, 100}; rprob = 100; arb_ctl = 1'b1; prio_en_ctl = 1'b0;
        drain("soak", 3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
